// File: rtl/res_st_issue_arbiter.sv
// rtl/res_st_issue_arbiter.sv - round-robin issue scheduler between reservation station and ALU
// Offers one ready entry at a time; a handshake frees the entry and re-arbitrates in the same edge.
module res_st_issue_arbiter #(
  parameter int RS_DEPTH  = 32,
  parameter int RS_ADDR_W = $clog2(RS_DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [RS_DEPTH-1:0]  busy_i,
  input  logic [RS_DEPTH-1:0]  ready_i,
  input  logic                 flush_i,
  output logic                 issue_valid_o,
  output logic [RS_ADDR_W-1:0] issue_idx_o,
  input  logic                 issue_ready_i,
  output logic                 clear_o,
  output logic [RS_ADDR_W-1:0] clear_idx_o,
  output logic [15:0]          issue_cnt_o
);

  typedef enum logic {IDLE, OFFER} state_t;

  state_t               state_q, state_d;
  logic [RS_ADDR_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [RS_ADDR_W-1:0] idx_d;
  logic [15:0]          cnt_d;

  logic [RS_DEPTH-1:0]  cand;
  logic [RS_DEPTH-1:0]  offered_bit;
  logic [RS_DEPTH-1:0]  search_mask;
  logic [RS_ADDR_W-1:0] search_start;
  logic [RS_ADDR_W-1:0] probe;
  logic [RS_ADDR_W-1:0] sel_idx;
  logic                 sel_found;
  logic                 hs;

  assign cand          = busy_i & ready_i;
  assign offered_bit   = {{(RS_DEPTH-1){1'b0}}, 1'b1} << issue_idx_o;
  assign issue_valid_o = (state_q == OFFER);
  assign hs            = issue_valid_o & issue_ready_i & ~flush_i;
  assign clear_o       = hs;
  assign clear_idx_o   = issue_idx_o;

  // While offering, the offered entry is being freed at this edge, so exclude it and search past it.
  always_comb begin
    if (state_q == OFFER) begin
      search_start = issue_idx_o + 1'b1;
      search_mask  = cand & ~offered_bit;
    end else begin
      search_start = rr_ptr_q;
      search_mask  = cand;
    end
  end

  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    probe     = '0;
    for (int k = 0; k < RS_DEPTH; k++) begin
      probe = search_start + RS_ADDR_W'(k);
      if (!sel_found && search_mask[probe]) begin
        sel_found = 1'b1;
        sel_idx   = probe;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    idx_d    = issue_idx_o;
    cnt_d    = issue_cnt_o;
    case (state_q)
      IDLE: begin
        if (!flush_i && sel_found) begin
          idx_d   = sel_idx;
          state_d = OFFER;
        end
      end
      OFFER: begin
        if (flush_i) begin
          state_d = IDLE;
        end else if (hs) begin
          rr_ptr_d = issue_idx_o + 1'b1;
          cnt_d    = issue_cnt_o + 16'd1;
          if (sel_found) begin
            idx_d = sel_idx;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      issue_idx_o <= '0;
      issue_cnt_o <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      issue_idx_o <= idx_d;
      issue_cnt_o <= cnt_d;
    end
  end

endmodule

// File: doc/res_st_issue_arbiter.md
# res_st_issue_arbiter

Round-robin issue scheduler for the reservation station. Each cycle it scans the entries that are both occupied and operand-ready, and selects one. It offers that entry's index to the execution unit over a valid/ready handshake. When the offer is accepted, it pulses a clear back to the reservation station so the entry is freed. It sits between the reservation-station storage array (`res_st_cell_t` entries) and the ALU issue port, and sustains one issue per cycle under continuous acceptance.

## Interface
Parameters:
- `RS_DEPTH`, default `RES_ST_DEPTH` (32): number of reservation-station entries; must be a power of two, at least 2.
- `RS_ADDR_W`, default `$clog2(RS_DEPTH)` (5): entry index width; must not be overridden.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  clock, all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `busy_i`  in  RS_DEPTH  per-entry occupied flag (`busy` field).
- `ready_i`  in  RS_DEPTH  per-entry operands resolved (qj and qk both cleared).
- `flush_i`  in  1  pipeline flush; aborts any offer.
- `issue_valid_o`  out  1  registered; an entry is offered.
- `issue_idx_o`  out  RS_ADDR_W  registered; index of the offered entry.
- `issue_ready_i`  in  1  execution unit accepts the offer this cycle.
- `clear_o`  out  1  combinational; the offered entry is consumed and must be freed at the next edge.
- `clear_idx_o`  out  RS_ADDR_W  equals `issue_idx_o`.
- `issue_cnt_o`  out  16  registered count of accepted issues; wraps modulo 2^16.

## Operation
- Candidate vector: `cand = busy_i & ready_i`.
- Round-robin pointer `rr_ptr` (RS_ADDR_W bits). Selection returns the first set bit of the search mask, scanning `rr_ptr`, `rr_ptr+1`, … up to `RS_DEPTH-1`, then wrapping to 0 and continuing to `rr_ptr-1`. All index arithmetic is modulo RS_DEPTH.
- Handshake: `hs = issue_valid_o & issue_ready_i & ~flush_i`; `clear_o = hs`.

State machine with states IDLE and OFFER. `issue_valid_o` is 1 exactly when the state is OFFER.

IDLE:
- `flush_i` high: stay in IDLE.
- Otherwise, if `cand` is nonzero: load `issue_idx_o` with the selected index and go to OFFER.
- Otherwise stay in IDLE.

OFFER:
- `flush_i` high (highest priority): go to IDLE. `clear_o` is 0, `rr_ptr` and `issue_cnt_o` are unchanged, whatever `issue_ready_i` is.
- `hs` high:
  - `rr_ptr` becomes `issue_idx_o+1`; `issue_cnt_o` increments by 1.
  - Re-select with search start `issue_idx_o+1`, using `cand` with bit `issue_idx_o` masked off (the reservation station frees that entry at this same edge).
  - If a candidate is found, load `issue_idx_o` and stay in OFFER. Otherwise go to IDLE.
- Neither: hold. `issue_idx_o` stays stable and re-arbitration is not performed, even if a higher-priority entry becomes ready.

Reservation-station contract:
- The reservation station drops `busy_i` of the offered entry only in response to `clear_o` or `flush_i`.
- If `busy_i[issue_idx_o]` is 0 during OFFER without either, that is a protocol violation. The bench asserts it never happens.

Reset values:
- `issue_valid_o` 0, `issue_idx_o` 0, `clear_o` 0, `issue_cnt_o` 0.
- State IDLE, `rr_ptr` 0.

## Timing
- Latency: a candidate first visible in cycle N (in IDLE) is offered in cycle N+1.
- Throughput: with `issue_ready_i` held at 1 and candidates always present, there is one handshake per cycle and `issue_valid_o` never drops.
- `clear_o` is asserted in the same cycle as the handshake; the entry is freed at the edge that ends that cycle.
- Offer stability: `issue_valid_o` and `issue_idx_o` change only on a handshake or a flush.
- `flush_i` and a handshake in the same cycle: the flush wins. No clear, no count, no pointer update.
- Wrap: after granting index `RS_DEPTH-1`, `rr_ptr` becomes 0.
- Reset asserted mid-offer: outputs go to their reset values immediately (asynchronous). The first offer can be made in the cycle after `rst` deasserts at the earliest.

## Test plan
- Reset: assert `rst` with random inputs. Expect `issue_valid_o`=0, `clear_o`=0, `issue_cnt_o`=0, `issue_idx_o`=0 throughout.
- Single issue:
  - Stimulus: `busy_i`=`ready_i`=bit 5 from cycle 0; `issue_ready_i`=1 from cycle 1.
  - Expect: cycle 1 `issue_valid_o`=1 with `issue_idx_o`=5 and `clear_o`=1; cycle 2 `issue_valid_o`=0; `issue_cnt_o`=1.
- Round-robin back-to-back:
  - Stimulus: entries 2, 7 and 30 ready; `issue_ready_i`=1; RS model clears `busy_i` on `clear_o`.
  - Expect: offers 2, 7, 30 in cycles 1, 2, 3, then `issue_valid_o`=0; `issue_cnt_o`=3.
- Backpressure:
  - Stimulus: entry 9 offered, `issue_ready_i`=0 for 4 cycles; entry 3 becomes ready in the meantime.
  - Expect: `issue_idx_o` stays 9 and `clear_o` stays 0 for those cycles; on acceptance, 9 is cleared and 3 is offered next.
- Flush vs handshake:
  - Stimulus: entry 12 offered; `flush_i`=1 and `issue_ready_i`=1 in the same cycle.
  - Expect: `clear_o`=0, `issue_valid_o`=0 in the next cycle, `issue_cnt_o` unchanged, `rr_ptr` unchanged.
- Wrap-around:
  - Stimulus: after granting 30 (`rr_ptr`=31), entries 0 and 31 are ready.
  - Expect: 31 is offered first, then 0.
